cache_arbiter: RTL and testbench

Arbitrates the single physical-memory (L2/pmem) port between the I-cache and D-cache miss engines of the pipelined LC-3b core. It sits between the two cache controllers' downstream interfaces and the memory, serialising line reads and writebacks. Each transaction is granted to one side, run to completion, and its response routed back. Both requesters are served fairly by alternating whenever both are pending.

---
 rtl/lc3b_types.sv | 29 ++
 rtl/cache_arbiter.sv | 121 ++++++++++++
 tb/tb_cache_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the memory-side blocks.
package lc3b_types;

  localparam int WORD_WIDTH   = 16;
  localparam int C_LINE_WIDTH = 128;

  typedef logic [WORD_WIDTH-1:0]   lc3b_word;
  typedef logic [C_LINE_WIDTH-1:0] lc3b_c_line;

  // Arbiter FSM: idle, or serving one of the two cache miss engines.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Which requester was granted; also used as the round-robin pointer.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_side_t;

  // Latched downstream operation.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares the single pmem port between the I-cache and D-cache miss engines.
// One transaction at a time; alternates between sides under contention.
// Request fields are captured at grant, so the downstream side sees stable
// values regardless of what the requester does mid-transaction.
module cache_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  import lc3b_types::*;

  arb_state_t            state, state_next;
  arb_side_t             last_grant;
  arb_side_t             grant_side;
  arb_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic i_req;
  logic d_req;
  logic grant_valid;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // Grant selection: a lone requester wins; under contention the side not
  // granted last time wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_side  = GRANT_I;
    grant_valid = i_req | d_req;
    if (d_req && (!i_req || last_grant == GRANT_I)) begin
      grant_side = GRANT_D;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE on the downstream pulse.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = (grant_side == GRANT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and grant-time capture of the winning request.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_valid) begin
        last_grant <= grant_side;
        if (grant_side == GRANT_D) begin
          addr_q  <= d_pmem_address;
          wdata_q <= d_pmem_wdata;
          // A simultaneous read and write from D is treated as a write.
          op_q    <= d_pmem_write ? OP_WRITE : OP_READ;
        end else begin
          addr_q  <= i_pmem_address;
          wdata_q <= '0;
          op_q    <= OP_READ;
        end
      end
    end
  end

  // Downstream strobes are Moore outputs: registered state and op only.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    if (state != IDLE) begin
      pmem_read  = (op_q == OP_READ);
      pmem_write = (op_q == OP_WRITE);
    end
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion is routed to the served side in the same cycle; a pulse in
  // IDLE matches no transaction and is dropped.
  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: grant, routing, fairness, latching,
// mid-transaction reset and stray downstream responses.
module tb_cache_arbiter;

  localparam int LW = 128;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int checks   = 0;
  int failures = 0;

  localparam logic [LW-1:0] LINE_A = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [LW-1:0] LINE_W = 128'hCAFE_F00D_0123_4567_89AB_CDEF_A5A5_5A5A;
  localparam logic [LW-1:0] LINE_B = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_FFFF_0001;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  // Simultaneous D read and write is an illegal request encoding.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(d_pmem_read && d_pmem_write))
        else $error("illegal D request: read and write both high");
    end
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let continuous assignments settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();

    // Reset state.
    check("rst_read",  pmem_read,    1'b0);
    check("rst_write", pmem_write,   1'b0);
    check("rst_addr",  pmem_address, 16'h0000);
    check("rst_wdata", pmem_wdata,   '0);
    check("rst_iresp", i_pmem_resp,  1'b0);
    check("rst_dresp", d_pmem_resp,  1'b0);
    reset = 1'b0;

    // Single I read: strobe one cycle after the request, zero-latency resp.
    tick();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0040;
    settle();
    check("i_no_comb_strobe", pmem_read, 1'b0);
    tick();
    check("i_read",      pmem_read,    1'b1);
    check("i_write",     pmem_write,   1'b0);
    check("i_addr",      pmem_address, 16'h0040);
    check("i_dresp_pre", d_pmem_resp,  1'b0);
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_A;
    settle();
    check("i_resp",  i_pmem_resp,  1'b1);
    check("i_rdata", i_pmem_rdata, LINE_A);
    check("i_dresp", d_pmem_resp,  1'b0);
    tick();
    idle_inputs();
    settle();
    check("i_after_read", pmem_read,   1'b0);
    check("i_after_resp", i_pmem_resp, 1'b0);

    // Contention right after reset: D wins first, then I after one idle cycle.
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0040;
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h1000;
    d_pmem_wdata   = LINE_W;
    tick();
    check("c_d_write", pmem_write,   1'b1);
    check("c_d_read",  pmem_read,    1'b0);
    check("c_d_addr",  pmem_address, 16'h1000);
    check("c_d_wdata", pmem_wdata,   LINE_W);
    pmem_resp = 1'b1;
    settle();
    check("c_d_resp",  d_pmem_resp, 1'b1);
    check("c_d_iresp", i_pmem_resp, 1'b0);
    tick();
    pmem_resp    = 1'b0;
    d_pmem_write = 1'b0;
    settle();
    check("c_idle_read",  pmem_read,  1'b0);
    check("c_idle_write", pmem_write, 1'b0);
    tick();
    check("c_i_read", pmem_read,    1'b1);
    check("c_i_addr", pmem_address, 16'h0040);
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_B;
    settle();
    check("c_i_resp",  i_pmem_resp,  1'b1);
    check("c_i_rdata", i_pmem_rdata, LINE_B);
    tick();
    idle_inputs();
    settle();

    // Continuous contention: last grant was I, so order is D, I, D, I.
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1111;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr%0d_addr", k), pmem_address, (k % 2 == 0) ? 16'h2222 : 16'h1111);
      check($sformatf("rr%0d_read", k), pmem_read, 1'b1);
      pmem_resp = 1'b1;
      settle();
      check($sformatf("rr%0d_dresp", k), d_pmem_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("rr%0d_iresp", k), i_pmem_resp, (k % 2 == 0) ? 1'b0 : 1'b1);
      tick();
      pmem_resp = 1'b0;
      settle();
      check($sformatf("rr%0d_gap", k), pmem_read, 1'b0);
    end
    idle_inputs();
    settle();

    // Requester address change mid-transaction is ignored.
    tick();
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h2000;
    tick();
    check("lat_addr0", pmem_address, 16'h2000);
    check("lat_read",  pmem_read,    1'b1);
    d_pmem_address = 16'h3000;
    tick();
    check("lat_addr1", pmem_address, 16'h2000);
    tick();
    check("lat_addr2", pmem_address, 16'h2000);
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_B;
    settle();
    check("lat_resp",  d_pmem_resp,  1'b1);
    check("lat_rdata", d_pmem_rdata, LINE_B);
    check("lat_addr3", pmem_address, 16'h2000);
    tick();
    idle_inputs();
    settle();

    // Reset in the middle of an I transaction.
    tick();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0040;
    tick();
    check("mr_read_pre", pmem_read, 1'b1);
    tick();
    reset = 1'b1;
    settle();
    check("mr_read",  pmem_read,    1'b0);
    check("mr_write", pmem_write,   1'b0);
    check("mr_addr",  pmem_address, 16'h0000);
    check("mr_iresp", i_pmem_resp,  1'b0);
    i_pmem_read = 1'b0;
    tick();
    reset = 1'b0;
    // Late response from the abandoned transaction.
    tick();
    pmem_resp = 1'b1;
    settle();
    check("late_iresp", i_pmem_resp, 1'b0);
    check("late_dresp", d_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    settle();
    check("late_idle", pmem_read, 1'b0);
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h4000;
    d_pmem_wdata   = LINE_W;
    tick();
    check("mr_d_write", pmem_write,   1'b1);
    check("mr_d_addr",  pmem_address, 16'h4000);
    check("mr_d_wdata", pmem_wdata,   LINE_W);
    pmem_resp = 1'b1;
    settle();
    check("mr_d_resp", d_pmem_resp, 1'b1);
    tick();
    idle_inputs();
    settle();

    // Stray response with nothing pending.
    tick();
    pmem_resp = 1'b1;
    settle();
    check("stray_iresp", i_pmem_resp, 1'b0);
    check("stray_dresp", d_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    settle();
    check("stray_read",  pmem_read,  1'b0);
    check("stray_write", pmem_write, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
